// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the fetch queue unit
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ENTRY_XLEN = 32;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    JREG   = 2'd2,
    RSVD   = 2'd3
  } redir_kind_t;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit_if : imem, decode-side and redirect signals of the fetch unit
// Rev 1.0
// ============================================================================
interface fetch_queue_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  imem_addr;
  logic             imem_en;
  logic [31:0]      imem_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_pc_plus4;

  logic             redir_valid;
  redir_kind_t      redir_kind;
  logic [XLEN-1:0]  redir_pc;
  logic [31:0]      redir_imm;
  logic [XLEN-1:0]  redir_reg;

  logic             misaligned;
  logic [CNT_W-1:0] count;

  modport master (
    output imem_addr, imem_en, out_valid, out_instr, out_pc, out_pc_plus4,
           misaligned, count,
    input  imem_rdata, out_ready, redir_valid, redir_kind, redir_pc,
           redir_imm, redir_reg
  );

  modport slave (
    input  imem_addr, imem_en, out_valid, out_instr, out_pc, out_pc_plus4,
           misaligned, count,
    output imem_rdata, out_ready, redir_valid, redir_kind, redir_pc,
           redir_imm, redir_reg
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : DEPTH-entry circular queue with flush, head entry zero when empty
// Rev 1.0
// ============================================================================
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output T                       head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head output is masked while empty instead.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[tail] <= push_data;
  end

  assign head_data = (count == '0) ? T'('0) : mem[head];

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit : fetch PC, redirect target computation and fetch queue
// Rev 1.0
// ============================================================================
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  fetch_queue_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_plus4;
  logic [XLEN-1:0]  redir_pc_plus4;
  logic [XLEN-1:0]  branch_off;
  logic [XLEN-1:0]  target;
  logic             redir_accept;
  logic             pop;
  logic             push;
  logic             misaligned_q;
  logic [CNT_W-1:0] count;
  entry_t           new_entry;
  entry_t           head;
  logic             unused_imm_bits;

  assign redir_accept   = bus.redir_valid & (bus.redir_kind != RSVD);
  assign pop            = bus.out_valid & bus.out_ready;
  assign push           = ~reset & ~redir_accept & ((count < CNT_W'(DEPTH)) | pop);
  assign fetch_pc_plus4 = fetch_pc + XLEN'(WORD_BYTES);
  assign redir_pc_plus4 = bus.redir_pc + XLEN'(WORD_BYTES);
  assign branch_off     = {{(XLEN-18){bus.redir_imm[15]}}, bus.redir_imm[15:0], 2'b00};
  assign unused_imm_bits = ^bus.redir_imm[31:26];

  always_comb begin
    target = fetch_pc;
    case (bus.redir_kind)
      BRANCH:  target = redir_pc_plus4 + branch_off;
      JUMP:    target = {redir_pc_plus4[XLEN-1:28], bus.redir_imm[25:0], 2'b00};
      JREG:    target = {bus.redir_reg[XLEN-1:2], 2'b00};
      default: target = fetch_pc;
    endcase
  end

  // Redirect wins over sequential fetch; the fifo is flushed by the same signal.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= redir_accept & (bus.redir_kind == JREG) & (|bus.redir_reg[1:0]);
      if (redir_accept)
        fetch_pc <= target;
      else if (push)
        fetch_pc <= fetch_pc_plus4;
    end
  end

  assign new_entry = '{instr: bus.imem_rdata, pc: fetch_pc, pc_plus4: fetch_pc_plus4};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (redir_accept),
    .count     (count),
    .head_data (head)
  );

  assign bus.imem_addr    = fetch_pc;
  assign bus.imem_en      = push;
  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc_plus4;
  assign bus.misaligned   = misaligned_q;
  assign bus.count        = count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue_unit : scoreboard bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_queue_unit_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb bus.imem_rdata = imem_word(bus.imem_addr);

  // Reference model state
  exp_t        exp_q[$];
  logic [31:0] m_pc   = RESET_PC;
  logic        m_mis  = 1'b0;
  logic        m_push = 1'b0;
  logic        armed  = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic logic [31:0] ref_target(logic [1:0] k, logic [31:0] pc,
                                             logic [31:0] imm, logic [31:0] r);
    int signed off;
    case (k)
      2'd0: begin
        off = int'($signed(imm[15:0]));
        return pc + 32'd4 + 32'(off * 4);
      end
      2'd1:    return ((pc + 32'd4) & 32'hF000_0000) | ((imm & 32'h03FF_FFFF) * 4);
      default: return r & ~32'd3;
    endcase
  endfunction

  function automatic logic accepted();
    return bus.redir_valid && (2'(bus.redir_kind) != 2'd3);
  endfunction

  // Model update at the active edge, from the inputs held during the cycle
  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_pc  = RESET_PC;
      m_mis = 1'b0;
      armed = 1'b1;
    end else begin
      m_mis = accepted() && (2'(bus.redir_kind) == 2'd2) && (bus.redir_reg[1:0] != 2'd0);
      if (accepted()) begin
        exp_q.delete();
        m_pc = ref_target(2'(bus.redir_kind), bus.redir_pc, bus.redir_imm, bus.redir_reg);
      end else if (m_push) begin
        exp_q.push_back('{instr: imem_word(m_pc), pc: m_pc, pc4: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Monitor: mid-cycle compare of DUT outputs against the scoreboard
  always @(negedge clock) begin
    if (armed) begin
      logic pop;
      chk("count", 32'(bus.count), 32'(exp_q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
      if (exp_q.size() != 0) begin
        chk("out_instr", bus.out_instr, exp_q[0].instr);
        chk("out_pc", bus.out_pc, exp_q[0].pc);
        chk("out_pc_plus4", bus.out_pc_plus4, exp_q[0].pc4);
      end else begin
        chk("empty_instr", bus.out_instr, 32'h0);
        chk("empty_pc", bus.out_pc, 32'h0);
      end
      pop    = (exp_q.size() != 0) && bus.out_ready;
      m_push = !reset && !accepted() && ((exp_q.size() < DEPTH) || pop);
      chk("imem_en", 32'(bus.imem_en), 32'(m_push));
      if (pop) void'(exp_q.pop_front());
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic redirect(logic [1:0] k, logic [31:0] pc, logic [31:0] imm, logic [31:0] r);
    bus.redir_valid = 1'b1;
    bus.redir_kind  = redir_kind_t'(k);
    bus.redir_pc    = pc;
    bus.redir_imm   = imm;
    bus.redir_reg   = r;
    step();
    bus.redir_valid = 1'b0;
  endtask

  initial begin
    bus.out_ready   = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_kind  = BRANCH;
    bus.redir_pc    = '0;
    bus.redir_imm   = '0;
    bus.redir_reg   = '0;
    step(2);
    reset = 1'b0;

    // Streaming with decode always ready
    step(12);

    // Back-pressure until full, then drain
    reset = 1'b1; step(); reset = 1'b0;
    bus.out_ready = 1'b0;
    step(10);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_imem_en", 32'(bus.imem_en), 32'd0);
    chk("full_fetch_pc", bus.imem_addr, 32'h10);
    bus.out_ready = 1'b1;
    step(8);

    // Branch backwards with three entries queued
    reset = 1'b1; step(); reset = 1'b0;
    bus.out_ready = 1'b0;
    step(3);
    redirect(2'd0, 32'h20, 32'h0000_FFFE, 32'h0);
    chk("branch_target", bus.imem_addr, 32'h1C);
    chk("branch_flush", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b1;
    step(4);

    // Jump and misaligned jump-register
    redirect(2'd1, 32'hF000_0010, 32'h0000_0040, 32'h0);
    chk("jump_target", bus.imem_addr, 32'hF000_0100);
    step(3);
    redirect(2'd2, 32'h0, 32'h0, 32'h0000_0203);
    chk("jreg_target", bus.imem_addr, 32'h200);
    chk("jreg_mis_pulse", 32'(bus.misaligned), 32'd1);
    step();
    chk("jreg_mis_clear", 32'(bus.misaligned), 32'd0);
    redirect(2'd3, 32'h40, 32'h0, 32'h0000_0001);
    chk("rsvd_no_mis", 32'(bus.misaligned), 32'd0);
    step(2);

    // Full queue: pop alone, then pop together with a redirect
    bus.out_ready = 1'b0;
    step(6);
    bus.out_ready = 1'b1;
    step();
    chk("full_pop_push", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b0;
    step(2);
    bus.out_ready = 1'b1;
    redirect(2'd2, 32'h0, 32'h0, 32'h0000_0100);
    chk("full_pop_redir", 32'(bus.count), 32'd0);
    step(3);

    // Back-to-back redirects, then fetch_pc wrap-around
    bus.redir_valid = 1'b1;
    bus.redir_kind  = JREG;
    bus.redir_reg   = 32'h0000_0400;
    step();
    redirect(2'd2, 32'h0, 32'h0, 32'hFFFF_FFF0);
    step(8);

    // Reset in mid-stream with a redirect pending
    bus.redir_valid = 1'b1;
    bus.redir_kind  = JREG;
    bus.redir_reg   = 32'h0000_0803;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.redir_valid = 1'b0;
    chk("mid_reset_pc", bus.imem_addr, RESET_PC);
    chk("mid_reset_count", 32'(bus.count), 32'd0);
    chk("mid_reset_mis", 32'(bus.misaligned), 32'd0);
    step(4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.redir_valid = ($urandom_range(0, 9) == 0);
      bus.redir_kind  = redir_kind_t'($urandom_range(0, 3));
      bus.redir_pc    = $urandom & ~32'd3;
      bus.redir_imm   = $urandom;
      bus.redir_reg   = $urandom;
      reset           = ($urandom_range(0, 199) == 0);
      if ((i % 100) > 90) bus.out_ready = 1'b0;
      step();
    end
    reset = 1'b0;
    bus.redir_valid = 1'b0;
    bus.out_ready = 1'b1;
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end that replaces the single-cycle PC/PC+4 path.
- Owns the fetch PC and drives the combinational instruction memory.
- Buffers fetched instructions, each with its PC and PC+4, in a DEPTH-entry circular queue, so decode can stall without losing fetches.
- Computes branch, jump and jump-register targets internally and flushes the queue on redirect.

Parameters:
XLEN, 32, data/address width (≥32)
DEPTH, 4, queue entries (power of two, ≥2)
RESET_PC, 0, fetch PC after reset (word aligned)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_addr  out  XLEN  address to instruction memory (= fetch_pc)
imem_en  out  1  fetch attempted this cycle
imem_rdata  in  32  instruction at imem_addr, same cycle (combinational memory)
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction
out_pc  out  XLEN  head PC
out_pc_plus4  out  XLEN  head PC+4
redir_valid  in  1  redirect request
redir_kind  in  2  0=BRANCH, 1=JUMP, 2=JREG, 3=reserved (ignored)
redir_pc  in  XLEN  PC of the redirecting instruction
redir_imm  in  32  raw instruction bits (imm16 in [15:0] for BRANCH, index26 in [25:0] for JUMP)
redir_reg  in  XLEN  register value for JREG
misaligned  out  1  one-cycle pulse: JREG target low bits nonzero
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC
  - queue empty; head/tail pointers 0; count=0
  - out_valid=0, misaligned=0
  - out_instr/out_pc/out_pc_plus4 = 0 while empty
- pop = out_valid & out_ready.
- Push rule: push = imem_en = ~reset & ~redir_accept & (count<DEPTH | pop).
  - Push and pop together when full is allowed; count stays unchanged.
- On push:
  - Entry {imem_rdata, fetch_pc, fetch_pc+4} is written at the tail.
  - tail advances, modulo DEPTH.
  - fetch_pc advances by 4.
- Fetch-to-visible latency:
  - An instruction fetched in cycle N is visible at the head in N+1 if the queue was empty.
  - Throughput is one instruction per cycle with out_ready held high.
- out_* signals are registered state (head entry); no combinational path from imem_rdata to out_*.
- redir_accept = redir_valid & (redir_kind != 3).
- Redirect target computation:
  - BRANCH: redir_pc + 4 + (sext(imm16) << 2)
  - JUMP: {(redir_pc+4)[XLEN-1:28], index26, 2'b00}
  - JREG: {redir_reg[XLEN-1:2], 2'b00}; misaligned=1 next cycle if redir_reg[1:0]!=0
- On redir_accept, at the next edge:
  - Queue flushed (count=0, head=tail=0).
  - fetch_pc=target.
  - No push that cycle.
  - Fetch resumes the following cycle; the first redirected instruction appears at the head 2 cycles after redir_valid.
- Redirect has priority over pop: a head consumed in the same cycle as a redirect is still counted as accepted by decode, but the queue is empty afterwards.
- Back-to-back redirects: each one overrides; the last accepted target wins.
- Wrap-around:
  - Pointers wrap at DEPTH.
  - fetch_pc wraps modulo 2^XLEN without error.
- Reset asserted mid-operation: all state returns to reset values at that edge; redirect and push inputs are ignored.
- Reserved redir_kind: no flush, no state change, misaligned stays 0.

Decomposition:
- Package fetch_pkg:
  - redir_kind_t enum (BRANCH, JUMP, JREG, RSVD)
  - fetch_entry_t struct {instr, pc, pc_plus4}
  - WORD_BYTES=4 constant
- Sub-module fetch_fifo:
  - Parametrised on DEPTH and entry type.
  - Ports: push, pop, flush, count, head data.
  - Holds the queue storage and pointers.
- Top level holds fetch_pc, target computation and push/redirect control.

Test Plan:
1. Reset, RESET_PC=0x0, out_ready=1, imem returns addr-derived words -> out_pc sequence 0x0,0x4,0x8… one per cycle from cycle 1; count holds 1.
2. out_ready=0 for 10 cycles after reset -> count saturates at 4; imem_en=0 once full; fetch_pc=0x10. Then raise out_ready -> heads 0x0..0xC in order, then 0x10, no gaps.
3. BRANCH redir_pc=0x20, imm16=0xFFFE while queue holds 3 entries -> next cycle count=0, out_valid=0; fetch_pc=0x1C; two cycles later out_pc=0x1C.
4. JUMP redir_pc=0xF000_0010, index26=0x40 -> target 0xF000_0100. JREG redir_reg=0x0000_0203 -> target 0x200, misaligned pulses for exactly one cycle.
5. Full queue with pop and redirect in the same cycle -> queue empty afterwards, no duplicate or lost count. Full queue with pop only -> push occurs, count stays 4.
6. Reset asserted mid-stream with redir_valid=1 -> fetch_pc=RESET_PC, count=0, misaligned=0; redirect ignored.
